// File: rtl/cond_exec_stage.sv
// Execute-stage pipeline register with ARM-style conditional execution.
// Holds the decoded instruction, evaluates its condition and owns the NZCV flags.
module cond_exec_stage (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_StallE,
   input  logic       i_FlushE,
   input  logic       i_PCSrcD,
   input  logic       i_RegWriteD,
   input  logic       i_MemtoRegD,
   input  logic       i_MemWriteD,
   input  logic       i_BranchD,
   input  logic       i_ALUSrcD,
   input  logic       i_FlagWriteD,
   input  logic [1:0] i_ALUControlD,
   input  logic [3:0] i_CondD,
   input  logic [3:0] i_ALUFlags,
   output logic [1:0] o_ALUControlE,
   output logic       o_ALUSrcE,
   output logic       o_MemtoRegE,
   output logic       o_RegWriteE,
   output logic       o_MemWriteE,
   output logic       o_PCSrcE,
   output logic       o_BranchTakenE,
   output logic       o_CondExE,
   output logic [3:0] o_Flags,
   output logic       o_ValidE
);

   logic       r_valid;
   logic       r_pcsrc;
   logic       r_regwrite;
   logic       r_memtoreg;
   logic       r_memwrite;
   logic       r_branch;
   logic       r_alusrc;
   logic       r_flagwrite;
   logic [1:0] r_aluctl;
   logic [3:0] r_cond;
   logic [3:0] r_flags;

   logic       w_cond_pass;
   logic       w_condex;
   logic       w_flag_we;
   logic       w_n;
   logic       w_z;
   logic       w_c;
   logic       w_v;

   assign {w_n, w_z, w_c, w_v} = r_flags;

   always_comb begin
      w_cond_pass = 1'b0;
      case (r_cond)
         4'b0000: w_cond_pass = w_z;
         4'b0001: w_cond_pass = !w_z;
         4'b0010: w_cond_pass = w_c;
         4'b0011: w_cond_pass = !w_c;
         4'b0100: w_cond_pass = w_n;
         4'b0101: w_cond_pass = !w_n;
         4'b0110: w_cond_pass = w_v;
         4'b0111: w_cond_pass = !w_v;
         4'b1000: w_cond_pass = w_c & !w_z;
         4'b1001: w_cond_pass = !w_c | w_z;
         4'b1010: w_cond_pass = (w_n == w_v);
         4'b1011: w_cond_pass = (w_n != w_v);
         4'b1100: w_cond_pass = !w_z & (w_n == w_v);
         4'b1101: w_cond_pass = w_z | (w_n != w_v);
         4'b1110: w_cond_pass = 1'b1;
         default: w_cond_pass = 1'b0;
      endcase
   end

   assign w_condex  = w_cond_pass & r_valid;
   assign w_flag_we = w_condex & r_flagwrite;

   // Pipeline register: flush wins over stall, a bubble is an AL no-op with valid=0.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid     <= 1'b0;
         r_pcsrc     <= 1'b0;
         r_regwrite  <= 1'b0;
         r_memtoreg  <= 1'b0;
         r_memwrite  <= 1'b0;
         r_branch    <= 1'b0;
         r_alusrc    <= 1'b0;
         r_flagwrite <= 1'b0;
         r_aluctl    <= 2'b00;
         r_cond      <= 4'b1110;
      end else if (i_FlushE) begin
         r_valid     <= 1'b0;
         r_pcsrc     <= 1'b0;
         r_regwrite  <= 1'b0;
         r_memtoreg  <= 1'b0;
         r_memwrite  <= 1'b0;
         r_branch    <= 1'b0;
         r_alusrc    <= 1'b0;
         r_flagwrite <= 1'b0;
         r_aluctl    <= 2'b00;
         r_cond      <= 4'b1110;
      end else if (!i_StallE) begin
         r_valid     <= 1'b1;
         r_pcsrc     <= i_PCSrcD;
         r_regwrite  <= i_RegWriteD;
         r_memtoreg  <= i_MemtoRegD;
         r_memwrite  <= i_MemWriteD;
         r_branch    <= i_BranchD;
         r_alusrc    <= i_ALUSrcD;
         r_flagwrite <= i_FlagWriteD;
         r_aluctl    <= i_ALUControlD;
         r_cond      <= i_CondD;
      end
   end

   // Flags commit at the end of the E cycle, so the next instruction sees them without forwarding.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_flags <= 4'b0000;
      end else if (w_flag_we) begin
         r_flags <= i_ALUFlags;
      end
   end

   assign o_ALUControlE  = r_aluctl;
   assign o_ALUSrcE      = r_alusrc;
   assign o_MemtoRegE    = r_memtoreg;
   assign o_ValidE       = r_valid;
   assign o_CondExE      = w_condex;
   assign o_RegWriteE    = r_regwrite & w_condex;
   assign o_MemWriteE    = r_memwrite & w_condex;
   assign o_PCSrcE       = r_pcsrc & w_condex;
   assign o_BranchTakenE = r_branch & w_condex;
   assign o_Flags        = r_flags;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Scoreboard bench for cond_exec_stage: directed pipeline scenarios plus random traffic
// checked against an instruction-level model of the E slot and the flag register.
module tb_cond_exec_stage;

   localparam int W = 14;

   typedef struct packed {
      logic       rw;
      logic       m2r;
      logic       mw;
      logic       pcs;
      logic       br;
      logic       asrc;
      logic       fw;
      logic [1:0] alu;
      logic [3:0] cond;
   } dins_t;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_StallE = 1'b0;
   logic       i_FlushE = 1'b0;
   logic       i_PCSrcD = 1'b0;
   logic       i_RegWriteD = 1'b0;
   logic       i_MemtoRegD = 1'b0;
   logic       i_MemWriteD = 1'b0;
   logic       i_BranchD = 1'b0;
   logic       i_ALUSrcD = 1'b0;
   logic       i_FlagWriteD = 1'b0;
   logic [1:0] i_ALUControlD = 2'b00;
   logic [3:0] i_CondD = 4'hE;
   logic [3:0] i_ALUFlags = 4'h0;
   logic [1:0] o_ALUControlE;
   logic       o_ALUSrcE;
   logic       o_MemtoRegE;
   logic       o_RegWriteE;
   logic       o_MemWriteE;
   logic       o_PCSrcE;
   logic       o_BranchTakenE;
   logic       o_CondExE;
   logic [3:0] o_Flags;
   logic       o_ValidE;

   cond_exec_stage dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_StallE       (i_StallE),
      .i_FlushE       (i_FlushE),
      .i_PCSrcD       (i_PCSrcD),
      .i_RegWriteD    (i_RegWriteD),
      .i_MemtoRegD    (i_MemtoRegD),
      .i_MemWriteD    (i_MemWriteD),
      .i_BranchD      (i_BranchD),
      .i_ALUSrcD      (i_ALUSrcD),
      .i_FlagWriteD   (i_FlagWriteD),
      .i_ALUControlD  (i_ALUControlD),
      .i_CondD        (i_CondD),
      .i_ALUFlags     (i_ALUFlags),
      .o_ALUControlE  (o_ALUControlE),
      .o_ALUSrcE      (o_ALUSrcE),
      .o_MemtoRegE    (o_MemtoRegE),
      .o_RegWriteE    (o_RegWriteE),
      .o_MemWriteE    (o_MemWriteE),
      .o_PCSrcE       (o_PCSrcE),
      .o_BranchTakenE (o_BranchTakenE),
      .o_CondExE      (o_CondExE),
      .o_Flags        (o_Flags),
      .o_ValidE       (o_ValidE)
   );

   // clock / reset
   always #5 i_clk = ~i_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   int n_vec = 0;
   int n_err = 0;
   logic [W-1:0] exp_q[$];

   // reference model state
   dins_t      m_e;
   bit         m_valid;
   logic [3:0] m_flags;

   // ARM condition: pairs of codes share a base test, odd code is the inverse.
   function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
      bit nn, zz, cc, vv, b;
      nn = f[3]; zz = f[2]; cc = f[1]; vv = f[0];
      case (c[3:1])
         3'd0: b = zz;
         3'd1: b = cc;
         3'd2: b = nn;
         3'd3: b = vv;
         3'd4: b = cc && !zz;
         3'd5: b = (nn == vv);
         3'd6: b = !zz && (nn == vv);
         default: return (c == 4'hE);
      endcase
      return c[0] ? !b : b;
   endfunction

   function automatic logic [W-1:0] exp_out();
      bit p;
      p = m_valid && cond_pass(m_e.cond, m_flags);
      return {m_e.alu, m_e.asrc, m_e.m2r, m_e.rw && p, m_e.mw && p, m_e.pcs && p,
              m_e.br && p, p, m_flags, m_valid};
   endfunction

   function automatic logic [W-1:0] dut_out();
      return {o_ALUControlE, o_ALUSrcE, o_MemtoRegE, o_RegWriteE, o_MemWriteE, o_PCSrcE,
              o_BranchTakenE, o_CondExE, o_Flags, o_ValidE};
   endfunction

   task automatic model_reset();
      m_e      = '0;
      m_e.cond = 4'hE;
      m_valid  = 1'b0;
      m_flags  = 4'h0;
   endtask

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // driver: present D plus the flags of the instruction in E, clock once, predict.
   task automatic apply(input dins_t d, input bit stall, input bit flush, input logic [3:0] alu);
      {i_RegWriteD, i_MemtoRegD, i_MemWriteD, i_PCSrcD, i_BranchD, i_ALUSrcD, i_FlagWriteD} =
         {d.rw, d.m2r, d.mw, d.pcs, d.br, d.asrc, d.fw};
      i_ALUControlD = d.alu;
      i_CondD       = d.cond;
      i_StallE      = stall;
      i_FlushE      = flush;
      i_ALUFlags    = alu;
      @(posedge i_clk);
      if (m_valid && m_e.fw && cond_pass(m_e.cond, m_flags)) m_flags = alu;
      if (flush) begin
         m_e      = '0;
         m_e.cond = 4'hE;
         m_valid  = 1'b0;
      end else if (!stall) begin
         m_e     = d;
         m_valid = 1'b1;
      end
      #1;
      exp_q.push_back(exp_out());
   endtask

   // scoreboard monitor
   always @(negedge i_clk) begin
      if (exp_q.size() != 0) chk("scoreboard", dut_out(), exp_q.pop_front());
   end

   function automatic dins_t mk(input bit rw, input bit mw, input bit pcs, input bit br,
                                input bit asrc, input bit fw, input logic [1:0] alu,
                                input logic [3:0] cond);
      dins_t d;
      d      = '0;
      d.rw   = rw;  d.mw = mw; d.pcs = pcs; d.br = br;
      d.asrc = asrc; d.fw = fw; d.alu = alu; d.cond = cond;
      return d;
   endfunction

   initial begin
      dins_t nop, adds, cmp, beq, bne, ge_i, lt_i, gt_i, nv_i, str_i, add_i, d;
      int guard;
      nop   = mk(0, 0, 0, 0, 0, 0, 2'b00, 4'hE);
      adds  = mk(1, 0, 0, 0, 0, 1, 2'b00, 4'hE);
      cmp   = mk(0, 0, 0, 0, 0, 1, 2'b01, 4'hE);
      beq   = mk(0, 0, 1, 1, 0, 0, 2'b00, 4'h0);
      bne   = mk(0, 0, 1, 1, 0, 0, 2'b00, 4'h1);
      ge_i  = mk(1, 0, 0, 0, 0, 0, 2'b00, 4'hA);
      lt_i  = mk(1, 0, 0, 0, 0, 0, 2'b00, 4'hB);
      gt_i  = mk(1, 0, 0, 0, 0, 0, 2'b00, 4'hC);
      nv_i  = mk(1, 1, 1, 1, 0, 0, 2'b00, 4'hF);
      str_i = mk(0, 1, 0, 0, 1, 0, 2'b11, 4'hE);
      add_i = mk(1, 0, 0, 0, 0, 0, 2'b00, 4'hE);
      model_reset();

      repeat (3) @(posedge i_clk);
      #1;
      chk("reset_state", dut_out(), W'(0));
      i_rst = 1'b0;

      // ADDS sets flags, RegWrite strobes in its E cycle
      apply(adds, 0, 0, 4'h0);
      chk("adds_regwrite", W'(o_RegWriteE), W'(1));
      apply(cmp, 0, 0, 4'b0100);
      chk("adds_flags", W'(o_Flags), W'(4'b0100));

      // CMP then BEQ / BNE back to back
      apply(beq, 0, 0, 4'b0100);
      chk("beq_taken", W'(o_BranchTakenE), W'(1));
      apply(cmp, 0, 0, 4'b0000);
      apply(bne, 0, 0, 4'b0100);
      chk("bne_not_taken", W'(o_BranchTakenE), W'(0));
      chk("bne_flags", W'(o_Flags), W'(4'b0100));

      // signed conditions with N=1, V=1
      apply(cmp, 0, 0, 4'b0000);
      apply(ge_i, 0, 0, 4'b1001);
      chk("ge_pass", W'(o_CondExE), W'(1));
      apply(lt_i, 0, 0, 4'h0);
      chk("lt_fail", W'(o_CondExE), W'(0));
      apply(gt_i, 0, 0, 4'h0);
      chk("gt_pass", W'(o_CondExE), W'(1));
      apply(nv_i, 0, 0, 4'h0);
      chk("nv_strobes", W'({o_CondExE, o_RegWriteE, o_MemWriteE, o_PCSrcE, o_BranchTakenE}),
          W'(0));

      // STR held for three stall cycles
      apply(str_i, 0, 0, 4'h0);
      for (int k = 0; k < 3; k++) begin
         apply(add_i, 1, 0, 4'($urandom_range(0, 15)));
         chk("stall_memwrite", W'(o_MemWriteE), W'(1));
         chk("stall_flags", W'(o_Flags), W'(4'b1001));
      end

      // flush beats stall
      apply(add_i, 1, 1, 4'h0);
      chk("flush_stall_valid", W'(o_ValidE), W'(0));
      chk("flush_stall_strobes",
          W'({o_CondExE, o_RegWriteE, o_MemWriteE, o_PCSrcE, o_BranchTakenE}), W'(0));

      // asynchronous reset with a flag write pending in E
      apply(adds, 0, 0, 4'h0);
      i_ALUFlags = 4'hF;
      @(negedge i_clk);
      #1;
      i_rst = 1'b1;
      #1;
      chk("async_rst_flags", W'(o_Flags), W'(0));
      chk("async_rst_valid", W'(o_ValidE), W'(0));
      chk("async_rst_regwrite", W'(o_RegWriteE), W'(0));
      @(posedge i_clk);
      #1;
      chk("rst_held_state", dut_out(), W'(0));
      model_reset();
      i_rst = 1'b0;

      // random traffic
      for (int k = 0; k < 400; k++) begin
         d = dins_t'($urandom);
         d.cond = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
         apply(d, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
               4'($urandom_range(0, 15)));
      end

      guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
         @(posedge i_clk);
         guard++;
      end
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
